// File: rtl/entropy_src_scheduler.sv
// Entropy source scheduler: shares one downstream conditioner among N_SRC
// entropy lanes. Round-robin grants a healthy lane, serialises WORD_W raw bits
// from it into a word, hands the word off with valid/ready, and permanently
// retires any lane that reports a permanent failure.
module entropy_src_scheduler #(
   parameter int N_SRC           = 4,
   parameter int WORD_W          = 32,
   parameter int WORDS_PER_GRANT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         src_bit,
   input  logic [N_SRC-1:0]         src_valid,
   input  logic [N_SRC-1:0]         src_perm_fail,
   output logic [N_SRC-1:0]         src_full,
   input  logic                     debug_mode,
   input  logic [$clog2(N_SRC)-1:0] debug_sel,
   output logic [WORD_W-1:0]        word_out,
   output logic                     word_valid,
   input  logic                     word_ready,
   output logic [$clog2(N_SRC)-1:0] active_src,
   output logic [N_SRC-1:0]         dead_mask,
   output logic                     all_failed
);

   localparam int IDX_W = $clog2(N_SRC);
   localparam int BIT_W = $clog2(WORD_W + 1);
   localparam int GNT_W = $clog2(WORDS_PER_GRANT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_COLLECT,
      S_HOLD,
      S_FAILED
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  rr;
   logic [WORD_W-2:0] shreg;       // MSB-side bits collected so far
   logic [BIT_W-1:0]  bit_cnt;
   logic [GNT_W-1:0]  grant_cnt;
   logic              dbg_grant;   // current grant was forced by debug_mode

   logic [N_SRC-1:0]  eligible;
   logic              all_dead;
   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [WORD_W-1:0] word_full;
   logic              last_bit;
   logic              last_grant;
   logic              lane_failed;

   // Control strobes from the FSM to the datapath.
   logic              load_grant;
   logic              load_rr;
   logic [IDX_W-1:0]  grant_idx;
   logic              shift_en;
   logic              emit;
   logic              abort;
   logic              accept;

   assign eligible   = src_valid & ~dead_mask;
   assign all_dead   = &dead_mask;
   assign word_full  = {shreg, src_bit[active_src]};
   assign last_bit   = (bit_cnt == BIT_W'(WORD_W - 1));
   assign last_grant = (grant_cnt == GNT_W'(WORDS_PER_GRANT - 1));
   // A debug-forced grant is allowed to run on a failed lane.
   assign lane_failed = (src_perm_fail[active_src] | dead_mask[active_src]) & ~dbg_grant;

   // Round-robin search: first eligible lane starting just after rr, wrapping.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         if (!hit && eligible[(int'(rr) + k) % N_SRC]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'((int'(rr) + k) % N_SRC);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // FSM next-state, lane throttling and datapath strobes.
   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_next = state;
      src_full   = '1;
      all_failed = 1'b0;
      load_grant = 1'b0;
      load_rr    = 1'b0;
      grant_idx  = hit_idx;
      shift_en   = 1'b0;
      emit       = 1'b0;
      abort      = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (all_dead)       state_next = S_FAILED;
            else if (|eligible) state_next = S_SELECT;
         end
         S_SELECT: begin
            if (debug_mode) begin
               load_grant = 1'b1;
               grant_idx  = debug_sel;
               state_next = S_COLLECT;
            end else if (hit) begin
               load_grant = 1'b1;
               load_rr    = 1'b1;
               state_next = S_COLLECT;
            end else if (all_dead) begin
               state_next = S_FAILED;
            end
         end
         S_COLLECT: begin
            src_full[active_src] = 1'b0;
            if (src_perm_fail[active_src] && !dbg_grant) begin
               abort      = 1'b1;
               state_next = S_SELECT;
            end else begin
               shift_en = 1'b1;
               if (last_bit) begin
                  emit       = 1'b1;
                  state_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (word_valid && word_ready) begin
               accept = 1'b1;
               if (last_grant || lane_failed) state_next = S_SELECT;
               else                           state_next = S_COLLECT;
            end
         end
         S_FAILED: begin
            all_failed = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: lane retirement, grant bookkeeping, bit collection and handoff.
   always_ff @(posedge clk) begin
      if (rst) begin
         dead_mask  <= '0;
         active_src <= '0;
         rr         <= IDX_W'(N_SRC - 1);
         dbg_grant  <= 1'b0;
         grant_cnt  <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
      end else begin
         dead_mask <= dead_mask | src_perm_fail;
         if (load_grant) begin
            active_src <= grant_idx;
            dbg_grant  <= debug_mode;
            grant_cnt  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
         end
         if (load_rr) rr <= grant_idx;
         // A failing lane's partial word is thrown away, including this cycle's bit.
         if (abort) begin
            bit_cnt <= '0;
            shreg   <= '0;
         end
         if (shift_en) begin
            if (emit) begin
               word_out   <= word_full;
               word_valid <= 1'b1;
               bit_cnt    <= '0;
               shreg      <= '0;
            end else begin
               shreg   <= word_full[WORD_W-2:0];
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
         end
         if (accept) begin
            word_valid <= 1'b0;
            grant_cnt  <= grant_cnt + GNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_entropy_src_scheduler.sv
// Directed bench for entropy_src_scheduler (N_SRC=4, WORD_W=8, WORDS_PER_GRANT=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_entropy_src_scheduler;

   localparam int N_SRC  = 4;
   localparam int WORD_W = 8;
   localparam int WPG    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_bit;
   logic [3:0] src_valid;
   logic [3:0] src_perm_fail;
   logic [3:0] src_full;
   logic       debug_mode;
   logic [1:0] debug_sel;
   logic [7:0] word_out;
   logic       word_valid;
   logic       word_ready;
   logic [1:0] active_src;
   logic [3:0] dead_mask;
   logic       all_failed;

   int checks = 0;
   int errors = 0;
   bit lane1_regrant = 1'b0;

   always #5 clk = ~clk;

   entropy_src_scheduler #(
      .N_SRC          (N_SRC),
      .WORD_W         (WORD_W),
      .WORDS_PER_GRANT(WPG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .src_bit      (src_bit),
      .src_valid    (src_valid),
      .src_perm_fail(src_perm_fail),
      .src_full     (src_full),
      .debug_mode   (debug_mode),
      .debug_sel    (debug_sel),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .active_src   (active_src),
      .dead_mask    (dead_mask),
      .all_failed   (all_failed)
   );

   // Watch for lane 1 being let through after it has been retired.
   always @(negedge clk) begin
      if (!rst && dead_mask[1] === 1'b1 && src_full[1] === 1'b0) lane1_regrant = 1'b1;
   end

   typedef struct {
      logic [3:0] valid;
      logic [3:0] bits;
      logic       dbg;
      logic [1:0] sel;
      logic [7:0] exp_word;
      logic [1:0] exp_lane;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Wait for the next word, count COLLECT cycles on the way, let it be accepted.
   task automatic get_word(output logic [7:0] w, output logic [1:0] lane, output int ncyc, output bit ok);
      ok   = 1'b0;
      ncyc = 0;
      w    = '0;
      lane = '0;
      for (int i = 0; i < 100; i++) begin
         if (word_valid === 1'b1) begin
            w    = word_out;
            lane = active_src;
            ok   = 1'b1;
            break;
         end
         if (src_full !== 4'hF) ncyc++;
         @(negedge clk);
      end
      if (ok) @(negedge clk);
   endtask

   task automatic expect_word(input string name, input logic [7:0] exp_w, input logic [1:0] exp_l);
      logic [7:0] w;
      logic [1:0] lane;
      int         ncyc;
      bit         ok;
      get_word(w, lane, ncyc, ok);
      check({name, " arrived"}, 32'(ok), 32'd1);
      check({name, " word"}, 32'(w), 32'(exp_w));
      check({name, " lane"}, 32'(lane), 32'(exp_l));
      check({name, " latency"}, 32'(ncyc), 32'd8);
   endtask

   task automatic run_vec(input int idx);
      src_valid  = vecs[idx].valid;
      src_bit    = vecs[idx].bits;
      debug_mode = vecs[idx].dbg;
      debug_sel  = vecs[idx].sel;
      expect_word($sformatf("vec%0d", idx), vecs[idx].exp_word, vecs[idx].exp_lane);
   endtask

   // Drive a serial MSB-first pattern on lane 2 while it collects.
   task automatic collect_pattern(input logic [7:0] pat, output logic [7:0] w, output logic [1:0] lane,
                                  output int ncyc, output int full_bad, output bit ok);
      int i;
      i        = 0;
      ok       = 1'b0;
      ncyc     = 0;
      full_bad = 0;
      w        = '0;
      lane     = '0;
      for (int c = 0; c < 100; c++) begin
         if (word_valid === 1'b1) begin
            w    = word_out;
            lane = active_src;
            ok   = 1'b1;
            break;
         end
         if (src_full !== 4'hF) begin
            ncyc++;
            if (src_full !== 4'b1011) full_bad++;
            if (i < 8) src_bit[2] = pat[7-i];
            i++;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " src_full"}, 32'(src_full), 32'hF);
      check({tag, " word_out"}, 32'(word_out), 32'h0);
      check({tag, " word_valid"}, 32'(word_valid), 32'h0);
      check({tag, " active_src"}, 32'(active_src), 32'h0);
      check({tag, " dead_mask"}, 32'(dead_mask), 32'h0);
      check({tag, " all_failed"}, 32'(all_failed), 32'h0);
   endtask

   initial begin
      logic [7:0] pats [3];
      logic [7:0] w;
      logic [1:0] lane;
      int         ncyc;
      int         full_bad;
      bit         ok;
      int         good_v;
      int         good_w;
      int         good_f;

      // Round robin over four healthy lanes with constant bits 1,0,1,0.
      vecs[0]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'hFF, 2'd0};
      vecs[1]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'hFF, 2'd0};
      vecs[2]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'h00, 2'd1};
      vecs[3]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'h00, 2'd1};
      vecs[4]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'hFF, 2'd2};
      vecs[5]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'hFF, 2'd2};
      vecs[6]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'h00, 2'd3};
      vecs[7]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'h00, 2'd3};
      vecs[8]  = '{4'hF, 4'b0101, 1'b0, 2'd0, 8'hFF, 2'd0};
      // Lanes 1 and 3 retired: rotation is 2,0,2,... with lane 2 bits 1, lane 0 bits 0.
      vecs[9]  = '{4'hF, 4'b0100, 1'b0, 2'd0, 8'hFF, 2'd2};
      vecs[10] = '{4'hF, 4'b0100, 1'b0, 2'd0, 8'hFF, 2'd2};
      vecs[11] = '{4'hF, 4'b0100, 1'b0, 2'd0, 8'h00, 2'd0};
      vecs[12] = '{4'hF, 4'b0100, 1'b0, 2'd0, 8'h00, 2'd0};
      vecs[13] = '{4'hF, 4'b0100, 1'b0, 2'd0, 8'hFF, 2'd2};
      // Debug: dead lane 3 forced, debug_sel/debug_mode changes mid-word wait for SELECT,
      // and rr stays at 2 so the normal search from lane 3 lands on lane 0.
      vecs[14] = '{4'b0101, 4'b1100, 1'b1, 2'd3, 8'hFF, 2'd3};
      vecs[15] = '{4'b0101, 4'b1100, 1'b1, 2'd0, 8'hFF, 2'd3};
      vecs[16] = '{4'b0101, 4'b1100, 1'b1, 2'd0, 8'h00, 2'd0};
      vecs[17] = '{4'b0101, 4'b1100, 1'b0, 2'd0, 8'h00, 2'd0};
      vecs[18] = '{4'b0101, 4'b1100, 1'b0, 2'd0, 8'h00, 2'd0};
      pats[0] = 8'hA5;
      pats[1] = 8'h3C;
      pats[2] = 8'h81;

      rst           = 1'b1;
      src_valid     = 4'hF;
      src_bit       = 4'b0101;
      src_perm_fail = 4'h0;
      debug_mode    = 1'b0;
      debug_sel     = 2'd0;
      word_ready    = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      for (int i = 0; i <= 8; i++) run_vec(i);

      // Backpressure on lane 0's second word.
      word_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (word_valid === 1'b1) break;
         @(negedge clk);
      end
      check("bp word_valid", 32'(word_valid), 32'd1);
      good_v = 0;
      good_w = 0;
      good_f = 0;
      for (int i = 0; i < 20; i++) begin
         if (word_valid === 1'b1) good_v++;
         if (word_out === 8'hFF) good_w++;
         if (src_full === 4'hF) good_f++;
         @(negedge clk);
      end
      check("bp valid held", 32'(good_v), 32'd20);
      check("bp word stable", 32'(good_w), 32'd20);
      check("bp lanes held", 32'(good_f), 32'd20);
      word_ready = 1'b1;
      @(negedge clk);
      check("bp accepted", 32'(word_valid), 32'd0);

      // Lane 1 fails after 3 bits of its first word.
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (src_full === 4'b1101) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("lane1 collecting", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      src_perm_fail = 4'b0010;
      @(negedge clk);
      check("pf1 dead_mask", 32'(dead_mask), 32'h2);
      check("pf1 no partial", 32'(word_valid), 32'd0);
      check("pf1 lanes held", 32'(src_full), 32'hF);
      src_perm_fail = 4'b1000;
      @(negedge clk);
      src_perm_fail = 4'h0;
      for (int i = 9; i <= 13; i++) run_vec(i);

      // Only lane 2 healthy: every grant stays on lane 2.
      src_valid = 4'b0100;
      src_bit   = 4'b0000;
      check("pf3 dead_mask", 32'(dead_mask), 32'hA);
      for (int p = 0; p < 3; p++) begin
         collect_pattern(pats[p], w, lane, ncyc, full_bad, ok);
         check($sformatf("pat%0d arrived", p), 32'(ok), 32'd1);
         check($sformatf("pat%0d word", p), 32'(w), 32'(pats[p]));
         check($sformatf("pat%0d lane", p), 32'(lane), 32'd2);
         check($sformatf("pat%0d latency", p), 32'(ncyc), 32'd8);
         check($sformatf("pat%0d src_full", p), 32'(full_bad), 32'd0);
      end

      for (int i = 14; i <= 18; i++) run_vec(i);

      // Every lane fails at once mid-word.
      src_valid     = 4'hF;
      src_perm_fail = 4'hF;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         src_perm_fail = 4'h0;
         if (all_failed === 1'b1) break;
      end
      check("fail all_failed", 32'(all_failed), 32'd1);
      check("fail word_valid", 32'(word_valid), 32'd0);
      check("fail src_full", 32'(src_full), 32'hF);
      check("fail dead_mask", 32'(dead_mask), 32'hF);
      repeat (5) @(negedge clk);
      check("fail sticky", 32'(all_failed), 32'd1);
      check("fail lanes held", 32'(src_full), 32'hF);

      // Recover through reset, then reset again in the middle of a lane-1 word.
      rst     = 1'b1;
      src_bit = 4'b0101;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      expect_word("rst1 w0", 8'hFF, 2'd0);
      expect_word("rst1 w1", 8'hFF, 2'd0);
      src_perm_fail = 4'b1000;
      @(negedge clk);
      src_perm_fail = 4'h0;
      repeat (2) @(negedge clk);
      check("mid collect src_full", 32'(src_full), 32'hD);
      check("mid collect active_src", 32'(active_src), 32'd1);
      check("mid collect dead_mask", 32'(dead_mask), 32'h8);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("rst2");
      rst = 1'b0;
      expect_word("rst2 w0", 8'hFF, 2'd0);

      check("lane1 regrant", 32'(lane1_regrant), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
